// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register and writeback logic of the 64-bit core.
// The memory-stage result (load data or ALU result) is merged with the old
// destination value according to the participation field (PPP). The merged
// value is registered at capture and presented to the register file write
// port one cycle later. The stage also exposes a forwarding copy of the
// pending write, a retired-instruction counter and the halt handshake.
//
// Bit numbering follows the core convention: bit 0 is the MSB, so "upper
// half [0:31]" is the most significant 32 bits, and byte 0 is the most
// significant byte.
//
// Ports
//   clk            core clock, all state updates on the rising edge
//   reset          asynchronous active-low reset (low = asserted)
//   mem_valid      MEM stage presents an instruction this cycle
//   mem_wr         instruction writes a register
//   mem_is_load    select mem_load_data (1) or mem_alu_result (0)
//   mem_rd_addr    destination register
//   mem_ppp        participation: 000 all, 001 upper half, 010 lower half,
//                  011 even bytes, 100 odd bytes, 101-111 treated as 000
//   mem_alu_result ALU result
//   mem_load_data  data memory read data
//   mem_rd_old     old destination value carried down the pipe
//   mem_halt       instruction is HALT
//   wb_stall       hold the stage: no capture, no write
//   writeEnable    register file write strobe
//   rD_address     register file write address
//   rD_data        register file write data
//   fwd_valid      pending write visible for forwarding
//   fwd_addr       forwarding address (same as rD_address)
//   fwd_data       forwarding data (same as rD_data)
//   retired_count  instructions retired since reset (wraps silently)
//   cpu_halted     core halted; only reset leaves this state
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_wr,
  input  logic              mem_is_load,
  input  logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [2:0]        mem_ppp,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_rd_old,
  input  logic              mem_halt,
  input  logic              wb_stall,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] rD_address,
  output logic [DATA_W-1:0] rD_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count,
  output logic              cpu_halted
);

  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Reset synchroniser: assertion propagates immediately (the flops clear
  // asynchronously), deassertion reaches the stage only after two clock
  // edges so that release never races the clock.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  // -------------------------------------------------------------------------
  // Lane selection: returns whether byte b (byte 0 = most significant)
  // takes the new value for a given participation code. Reserved codes fall
  // through to "all bytes".
  // -------------------------------------------------------------------------
  function automatic logic lane_active(input logic [2:0] ppp, input int b);
    logic act;
    act = 1'b1;
    case (ppp)
      3'b001:  act = (b < NBYTES / 2);
      3'b010:  act = (b >= NBYTES / 2);
      3'b011:  act = ((b % 2) == 0);
      3'b100:  act = ((b % 2) == 1);
      default: act = 1'b1;
    endcase
    return act;
  endfunction

  // -------------------------------------------------------------------------
  // Merge datapath, evaluated at capture time so that rD_data comes straight
  // from a flop.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] sel_value;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged_value;

  always_comb begin
    sel_value = mem_is_load ? mem_load_data : mem_alu_result;
    lane_mask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      lane_mask[DATA_W-1-8*b -: 8] = {8{lane_active(mem_ppp, b)}};
    end
    merged_value = (sel_value & lane_mask) | (mem_rd_old & ~lane_mask);
  end

  // -------------------------------------------------------------------------
  // Stage state
  // -------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic              valid_q,     valid_d;
  logic              wr_q,        wr_d;
  logic              halt_q,      halt_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic              halted_q,    halted_d;

  logic advance;
  logic retire;
  logic halt_now;

  // Next-state logic. "advance" is an edge on which the stage moves: the
  // held instruction retires and the next one is captured on the same edge.
  // A HALT retiring clears valid so nothing captured alongside it survives.
  always_comb begin
    advance  = (state_q == ST_RUN) && !wb_stall;
    retire   = advance && valid_q;
    halt_now = retire && halt_q;

    state_d   = state_q;
    valid_d   = valid_q;
    wr_d      = wr_q;
    halt_d    = halt_q;
    rd_addr_d = rd_addr_q;
    wb_data_d = wb_data_q;
    count_d   = count_q;
    halted_d  = halted_q;

    if (advance) begin
      valid_d   = mem_valid && !halt_now;
      wr_d      = mem_wr;
      halt_d    = mem_halt;
      rd_addr_d = mem_rd_addr;
      wb_data_d = merged_value;
    end

    if (retire) begin
      count_d = count_q + CNT_W'(1);
    end

    if (halt_now) begin
      state_d  = ST_HALTED;
      halted_d = 1'b1;
    end
  end

  // Single register block for the FSM and the pipeline payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      valid_q   <= 1'b0;
      wr_q      <= 1'b0;
      halt_q    <= 1'b0;
      rd_addr_q <= '0;
      wb_data_q <= '0;
      count_q   <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      wr_q      <= wr_d;
      halt_q    <= halt_d;
      rd_addr_q <= rd_addr_d;
      wb_data_q <= wb_data_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. A pending write is one that is valid, writes, targets a
  // register other than r0 and is not the HALT itself. Forwarding ignores
  // the stall so bypass still sees the held value; the strobe does not.
  // -------------------------------------------------------------------------
  logic pending_write;

  always_comb begin
    pending_write = valid_q && wr_q && !halt_q && (rd_addr_q != '0) &&
                    (state_q == ST_RUN);
  end

  assign writeEnable   = pending_write && !wb_stall;
  assign fwd_valid     = pending_write;
  assign rD_address    = rd_addr_q;
  assign rD_data       = wb_data_q;
  assign fwd_addr      = rd_addr_q;
  assign fwd_data      = wb_data_q;
  assign retired_count = count_q;
  assign cpu_halted    = halted_q;

endmodule
